// File: rtl/rx_iq_framer_pkg.sv
// Shared types for the RX IQ framer: FSM states and the sample/FIFO word layouts.
package rx_iq_framer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

  localparam int IQ_W = 32;

  // Q occupies the upper half of the DDC word, I the lower half.
  typedef struct packed {
    logic signed [15:0] q;
    logic signed [15:0] i;
  } iq_t;

  typedef struct packed {
    logic last;
    iq_t  data;
  } fifo_entry_t;

endpackage

// File: rtl/rx_iq_fifo.sv
// Synchronous FIFO with a registered first-word-fall-through output stage.
// count_o covers every stored word, including the one waiting in the output register.
module rx_iq_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_en_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   rd_valid_o,
  output logic [WIDTH-1:0]       rd_data_o,
  input  logic                   rd_ready_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d, mem_cnt;
  logic [WIDTH-1:0] out_q;
  logic             out_vld_q, out_vld_d;
  logic             push, pop, load;

  always_comb begin
    push      = wr_en_i && (count_q != FULL_CNT);
    pop       = out_vld_q && rd_ready_i;
    mem_cnt   = count_q - CW'(out_vld_q);
    // Only words already in memory before this edge may refill the output stage.
    load      = (!out_vld_q || pop) && (mem_cnt != '0);
    count_d   = count_q + CW'(push) - CW'(pop);
    out_vld_d = load ? 1'b1 : (pop ? 1'b0 : out_vld_q);
  end

  // NOTE: the storage array has no reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (load) begin
        out_q    <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q   <= count_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign full_o     = (count_q == FULL_CNT);
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign rd_valid_o = out_vld_q;
  assign rd_data_o  = out_q;

endmodule

// File: rtl/rx_iq_framer.sv
// Frames a non-stallable DDC IQ stream into fixed-length AXI-Stream packets,
// absorbing DMA backpressure in a FIFO and accounting for samples dropped on overflow.
module rx_iq_framer
  import rx_iq_framer_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 1024,
  parameter int LEN_W      = 16
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              enable,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic              clear_status,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              busy,
  output logic              overflow,
  output logic [LEN_W-1:0]  drop_count,
  output logic [LEN_W-1:0]  frame_count
);

  state_e                    state_q, state_d;
  logic [LEN_W-1:0]          len_q, len_d;
  logic [LEN_W-1:0]          cnt_q, cnt_d;
  logic                      overflow_q, overflow_d;
  logic [LEN_W-1:0]          drop_q, drop_d;
  logic [LEN_W-1:0]          frame_q, frame_d;

  logic                      fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                      unused_fifo_status;

  logic                      wr_attempt, wr_ok, drop, is_last, frame_done;
  logic [LEN_W-1:0]          norm_len;

  always_comb begin
    wr_attempt = (state_q != IDLE) && s_axis_tvalid;
    wr_ok      = wr_attempt && !fifo_full;
    drop       = wr_attempt && fifo_full;
    is_last    = (cnt_q == len_q - 1'b1);
    frame_done = wr_ok && is_last;
    norm_len   = (frame_len == '0) ? LEN_W'(1) : frame_len;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = RUN;
          len_d   = norm_len;
          cnt_d   = '0;
        end
      end
      RUN, STOP: begin
        if (wr_ok) begin
          if (is_last) begin
            cnt_d = '0;
            len_d = norm_len;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        // Decide on the post-write counter so a frame finishing this cycle is not reopened.
        if (state_q == RUN && !enable) begin
          state_d = (cnt_d == '0) ? IDLE : STOP;
        end else if (state_q == STOP && cnt_d == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q | drop;
    drop_d     = (drop && drop_q != '1) ? drop_q + 1'b1 : drop_q;
    frame_d    = frame_done ? frame_q + 1'b1 : frame_q;
    if (clear_status) begin
      overflow_d = 1'b0;
      drop_d     = '0;
      frame_d    = '0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
      frame_q    <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      frame_q    <= frame_d;
    end
  end

  rx_iq_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (aclk),
    .rst_i      (areset),
    .wr_en_i    (wr_ok),
    .wr_data_i  ({is_last, s_axis_tdata}),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count),
    .rd_valid_o (m_axis_tvalid),
    .rd_data_o  ({m_axis_tlast, m_axis_tdata}),
    .rd_ready_i (m_axis_tready)
  );

  assign unused_fifo_status = fifo_empty ^ (^fifo_count);

  assign busy        = (state_q != IDLE);
  assign overflow    = overflow_q;
  assign drop_count  = drop_q;
  assign frame_count = frame_q;

endmodule

// File: tb/tb_rx_iq_framer.sv
// Bench for rx_iq_framer: directed scenarios plus random traffic, all checked every
// cycle against a queue-based model of the framing and FIFO rules.
module tb_rx_iq_framer;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int LW    = 16;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          enable = 1'b0;
  logic [LW-1:0] frame_len = '0;
  logic          clear_status = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tlast;
  logic          busy;
  logic          overflow;
  logic [LW-1:0] drop_count;
  logic [LW-1:0] frame_count;

  always #5 aclk = ~aclk;

  rx_iq_framer #(
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH),
    .LEN_W      (LW)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .enable        (enable),
    .frame_len     (frame_len),
    .clear_status  (clear_status),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .overflow      (overflow),
    .drop_count    (drop_count),
    .frame_count   (frame_count)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue of stored words, each tagged with the edge that wrote it.
  // A word is presentable once at least one further edge has passed since its write.
  typedef struct {
    logic [DW-1:0] data;
    bit            last;
    longint        wedge;
  } entry_t;

  entry_t        mq[$];
  int            m_mode = 0;   // 0 idle, 1 run, 2 stop
  int            m_len = 0;
  int            m_pos = 0;
  bit            m_ovf = 1'b0;
  logic [LW-1:0] m_drops = '0;
  logic [LW-1:0] m_frames = '0;
  longint        ecnt = 0;
  int            hs_cnt = 0;

  always @(posedge aclk or posedge areset) begin
    if (areset) begin
      mq.delete();
      m_mode   = 0;
      m_len    = 0;
      m_pos    = 0;
      m_ovf    = 1'b0;
      m_drops  = '0;
      m_frames = '0;
    end else begin
      automatic int sz   = mq.size();
      automatic bit pop  = (sz > 0) && (mq[0].wedge + 1 < ecnt) && m_axis_tready;
      automatic bit drp  = 1'b0;
      if (pop) hs_cnt++;
      if (m_mode == 0) begin
        if (enable) begin
          m_mode = 1;
          m_len  = (frame_len == 0) ? 1 : int'(frame_len);
          m_pos  = 0;
        end
      end else begin
        if (s_axis_tvalid) begin
          if (sz < DEPTH) begin
            automatic bit lst = (m_pos == m_len - 1);
            mq.push_back('{data: s_axis_tdata, last: lst, wedge: ecnt});
            if (lst) begin
              m_pos = 0;
              m_frames++;
              m_len = (frame_len == 0) ? 1 : int'(frame_len);
            end else begin
              m_pos++;
            end
          end else begin
            drp = 1'b1;
          end
        end
        if (m_mode == 1 && !enable) m_mode = (m_pos == 0) ? 0 : 2;
        else if (m_mode == 2 && m_pos == 0) m_mode = 0;
      end
      if (drp) begin
        m_ovf = 1'b1;
        if (m_drops != '1) m_drops++;
      end
      if (clear_status) begin
        m_ovf    = 1'b0;
        m_drops  = '0;
        m_frames = '0;
      end
      if (pop) void'(mq.pop_front());
      ecnt++;
    end
  end

  always @(negedge aclk) begin
    automatic bit exp_v = (mq.size() > 0) && (mq[0].wedge + 1 < ecnt);
    check("tvalid", m_axis_tvalid, exp_v);
    if (exp_v) begin
      check("tdata", m_axis_tdata, mq[0].data);
      check("tlast", m_axis_tlast, mq[0].last);
    end
    check("busy", busy, m_mode != 0);
    check("overflow", overflow, m_ovf);
    check("drop_count", drop_count, m_drops);
    check("frame_count", frame_count, m_frames);
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [DW-1:0] d);
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    tick();
    s_axis_tvalid = 1'b0;
  endtask

  initial begin
    int hs0;
    repeat (3) tick();
    areset = 1'b0;
    tick();
    @(negedge aclk);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_frames", frame_count, 0);

    // 1: length 4, free-flowing output, 8 samples
    frame_len = 4; m_axis_tready = 1'b1; enable = 1'b1;
    tick();
    for (int i = 1; i <= 8; i++) begin
      s_axis_tdata  = i * 32'h0001_0001;
      s_axis_tvalid = 1'b1;
      tick();
      if (i == 1) begin
        @(negedge aclk);
        check("t1_lat_early", m_axis_tvalid, 0);
      end
      if (i == 2) begin
        @(negedge aclk);
        check("t1_lat_valid", m_axis_tvalid, 1);
        check("t1_lat_data", m_axis_tdata, 32'h0001_0001);
      end
    end
    s_axis_tvalid = 1'b0;
    idle_cycles(4);
    @(negedge aclk);
    check("t1_frames", frame_count, 2);
    enable = 1'b0;
    idle_cycles(2);

    // 2: overflow with the sink stalled
    frame_len = 4; m_axis_tready = 1'b0; enable = 1'b1;
    tick();
    for (int i = 1; i <= 6; i++) send(32'hA000_0000 + i);
    idle_cycles(1);
    @(negedge aclk);
    check("t2_overflow", overflow, 1);
    check("t2_drops", drop_count, 2);
    check("t2_head", m_axis_tdata, 32'hA000_0001);
    hs0 = hs_cnt;
    m_axis_tready = 1'b1;
    idle_cycles(8);
    check("t2_popped", hs_cnt - hs0, 4);
    enable = 1'b0; clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    @(negedge aclk);
    check("t2_cleared", overflow, 0);

    // 3: partial frame finished in STOP, later samples ignored
    frame_len = 5; enable = 1'b1;
    tick();
    send(32'hB000_0001);
    send(32'hB000_0002);
    enable = 1'b0;
    tick();
    @(negedge aclk);
    check("t3_stop_busy", busy, 1);
    for (int i = 3; i <= 5; i++) send(32'hB000_0000 + i);
    tick();
    @(negedge aclk);
    check("t3_idle_busy", busy, 0);
    for (int i = 6; i <= 8; i++) send(32'hB000_0000 + i);
    idle_cycles(3);
    @(negedge aclk);
    check("t3_drops", drop_count, 0);
    check("t3_frames", frame_count, 1);

    // 4: length change mid-frame applies from the next frame
    clear_status = 1'b1; frame_len = 4; enable = 1'b1;
    tick();
    clear_status = 1'b0;
    send(32'hC000_0001);
    frame_len = 2;
    for (int i = 2; i <= 6; i++) send(32'hC000_0000 + i);
    enable = 1'b0;
    idle_cycles(4);
    @(negedge aclk);
    check("t4_frames", frame_count, 2);

    // 5: reset mid-frame with words buffered
    frame_len = 8; m_axis_tready = 1'b0; enable = 1'b1;
    tick();
    for (int i = 1; i <= 3; i++) send(32'hD000_0000 + i);
    areset = 1'b1;
    #1;
    check("t5_tvalid", m_axis_tvalid, 0);
    check("t5_frames", frame_count, 0);
    check("t5_busy", busy, 0);
    m_axis_tready = 1'b1;
    tick();
    areset = 1'b0;
    tick();
    for (int i = 1; i <= 8; i++) send(32'hE000_0000 + i);
    idle_cycles(4);
    @(negedge aclk);
    check("t5_after_frames", frame_count, 1);

    // 6: zero length means one-sample frames; clear beats the final increment
    enable = 1'b0;
    tick();
    frame_len = 0; enable = 1'b1;
    tick();
    send(32'hF000_0001);
    send(32'hF000_0002);
    clear_status = 1'b1;
    send(32'hF000_0003);
    clear_status = 1'b0;
    idle_cycles(3);
    @(negedge aclk);
    check("t6_frames", frame_count, 0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 3) enable = ~enable;
      s_axis_tvalid = ($urandom_range(0, 99) < 70);
      s_axis_tdata  = $urandom;
      m_axis_tready = ($urandom_range(0, 99) < 60);
      frame_len     = LW'($urandom_range(0, 6));
      clear_status  = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 999) < 3) begin
        areset = 1'b1;
        tick();
        areset = 1'b0;
      end
      tick();
    end
    s_axis_tvalid = 1'b0; clear_status = 1'b0; enable = 1'b0; m_axis_tready = 1'b1;
    idle_cycles(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
